// File: rtl/seg_pkg.sv
// Shared segment codes and BCD-to-seven-segment decode for the scan display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // 0-9 are digits, A is a minus sign, B-F are blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            4'hA:    s = SEG_MINUS;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble to seven-segment decoder (active-low segments).
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure table lookup through the shared package function.
    always_comb seg = bcd_to_seg(nibble);

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed N-digit seven-segment scan driver with staged,
// frame-synchronous data loading, blink, leading-zero and ghost blanking.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int DIV_BITS     = 17,
    parameter int BLANK_CYCLES = 1024,
    parameter int BLINK_BITS   = 26
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  lz_blank,
    output logic [N_DIGITS-1:0]   AN,
    output logic [6:0]            seg,
    output logic                  DP,
    output logic                  frame_sync,
    output logic                  pending
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [DIV_BITS-1:0] BLANK_LIM = DIV_BITS'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [DIV_BITS-1:0]   dwell;
    logic [IDX_W-1:0]      idx;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  boundary;

    // Staging (written by load) and shadow (drives the display) copies.
    logic [4*N_DIGITS-1:0] st_digits, sh_digits;
    logic [N_DIGITS-1:0]   st_en, sh_en, st_dp, sh_dp, st_blink, sh_blink;
    logic                  st_lz, sh_lz;
    logic                  pending_q;

    logic [3:0]            cur_nib;
    logic                  cur_en, cur_dp, cur_blink, lz_hit, dark;
    logic [6:0]            cur_seg;

    logic [N_DIGITS-1:0]   an_p1;
    logic [6:0]            seg_p1;
    logic                  dp_p1, vld_p1;

    assign boundary = (&dwell) && (idx == IDX_LAST);

    // Dwell, scan index and blink counters; all free-running.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            dwell     <= '0;
            idx       <= '0;
            blink_cnt <= '0;
        end else begin
            dwell     <= dwell + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            if (&dwell)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Staging/shadow handoff: a load on the boundary bypasses staging so it
    // appears in the very next frame; otherwise the last load before a
    // boundary is the one promoted.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            st_digits <= '0; st_en <= '0; st_dp <= '0; st_blink <= '0; st_lz <= 1'b0;
            sh_digits <= '0; sh_en <= '0; sh_dp <= '0; sh_blink <= '0; sh_lz <= 1'b0;
            pending_q <= 1'b0;
        end else if (boundary && load) begin
            sh_digits <= digits; sh_en <= digit_en; sh_dp <= dp_mask;
            sh_blink  <= blink_mask; sh_lz <= lz_blank;
            pending_q <= 1'b0;
        end else if (boundary && pending_q) begin
            sh_digits <= st_digits; sh_en <= st_en; sh_dp <= st_dp;
            sh_blink  <= st_blink; sh_lz <= st_lz;
            pending_q <= 1'b0;
        end else if (load) begin
            st_digits <= digits; st_en <= digit_en; st_dp <= dp_mask;
            st_blink  <= blink_mask; st_lz <= lz_blank;
            pending_q <= 1'b1;
        end
    end

    // Select the scanned digit's attributes and evaluate leading-zero blanking:
    // blank when every enabled digit at or left of idx holds zero.
    always_comb begin
        cur_nib   = 4'h0;
        cur_en    = 1'b0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        lz_hit    = sh_lz && (idx != '0);
        for (int j = 0; j < N_DIGITS; j++) begin
            if (idx == IDX_W'(j)) begin
                cur_nib   = sh_digits[4*j +: 4];
                cur_en    = sh_en[j];
                cur_dp    = sh_dp[j];
                cur_blink = sh_blink[j];
            end
            if ((j >= int'(idx)) && sh_en[j] && (sh_digits[4*j +: 4] != 4'h0))
                lz_hit = 1'b0;
        end
    end

    seg_decoder u_dec (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Dark when disabled, within the ghost-blank window, in blink-off phase,
    // or leading-zero blanked.
    always_comb begin
        dark = !cur_en || (dwell < BLANK_LIM)
            || (cur_blink && blink_cnt[BLINK_BITS-1]) || lz_hit;
    end

    // ---- stage p1: registered pin drive ----
    // Output registers; one cycle behind the counter/shadow state.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            an_p1  <= '1;
            seg_p1 <= SEG_BLANK;
            dp_p1  <= 1'b1;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= (dwell == '0) && (idx == '0);
            if (dark) begin
                an_p1  <= '1;
                seg_p1 <= SEG_BLANK;
                dp_p1  <= 1'b1;
            end else begin
                an_p1  <= ~(N_DIGITS'(1) << idx);
                seg_p1 <= cur_seg;
                dp_p1  <= ~cur_dp;
            end
        end
    end

    assign AN         = an_p1;
    assign seg        = seg_p1;
    assign DP         = dp_p1;
    assign frame_sync = vld_p1;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with a time-based reference model.
module tb_seg_scan_display;

    localparam int FRAME = 32;   // 4 digits * 8 clocks
    localparam int DWELL = 8;

    logic        CLK100MHZ = 1'b0;
    logic        rst = 1'b1, load = 1'b0, lz_blank = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  digit_en = '0, dp_mask = '0, blink_mask = '0;
    logic [3:0]  AN;
    logic [6:0]  seg;
    logic        DP, frame_sync, pending;

    int checks = 0;
    int failures = 0;

    // Reference model: k = clocks since reset released; shown/staged data.
    int          k = 0;
    logic [15:0] m_dig = '0, s_dig = '0;
    logic [3:0]  m_en = '0, m_dp = '0, m_blk = '0, s_en = '0, s_dp = '0, s_blk = '0;
    logic        m_lz = 1'b0, s_lz = 1'b0, m_pend = 1'b0;
    logic [6:0]  seg_tab [16];

    seg_scan_display #(
        .N_DIGITS(4), .DIV_BITS(3), .BLANK_CYCLES(2), .BLINK_BITS(7)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .rst        (rst),
        .load       (load),
        .digits     (digits),
        .digit_en   (digit_en),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .lz_blank   (lz_blank),
        .AN         (AN),
        .seg        (seg),
        .DP         (DP),
        .frame_sync (frame_sync),
        .pending    (pending)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // What the pins should show for the state at time k with the shown data.
    task automatic model_out(output logic [3:0] an, output logic [6:0] sg, output logic dp);
        int  dw, ix;
        bit  phase, lz, dark;
        logic [3:0] nib;
        dw    = k % DWELL;
        ix    = (k / DWELL) % 4;
        phase = ((k / 64) % 2) == 1;
        nib   = m_dig[ix*4 +: 4];
        lz    = m_lz && (ix != 0);
        for (int j = ix; j < 4; j++)
            if (m_en[j] && (m_dig[j*4 +: 4] != 4'h0)) lz = 1'b0;
        dark = !m_en[ix] || (dw < 2) || (m_blk[ix] && phase) || lz;
        if (dark) begin
            an = 4'hF; sg = 7'h7F; dp = 1'b1;
        end else begin
            an = 4'hF; an[ix] = 1'b0;
            sg = seg_tab[nib];
            dp = !m_dp[ix];
        end
    endtask

    task automatic tick();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fs;
        if (rst) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
            k = 0; m_pend = 1'b0;
            m_dig = '0; m_en = '0; m_dp = '0; m_blk = '0; m_lz = 1'b0;
            s_dig = '0; s_en = '0; s_dp = '0; s_blk = '0; s_lz = 1'b0;
        end else begin
            model_out(e_an, e_seg, e_dp);
            e_fs = (k % FRAME) == 0;
            if ((k % FRAME) == FRAME - 1) begin
                if (load) begin
                    m_dig = digits; m_en = digit_en; m_dp = dp_mask; m_blk = blink_mask; m_lz = lz_blank;
                end else if (m_pend) begin
                    m_dig = s_dig; m_en = s_en; m_dp = s_dp; m_blk = s_blk; m_lz = s_lz;
                end
                m_pend = 1'b0;
            end else if (load) begin
                s_dig = digits; s_en = digit_en; s_dp = dp_mask; s_blk = blink_mask; s_lz = lz_blank;
                m_pend = 1'b1;
            end
            k++;
        end
        @(posedge CLK100MHZ);
        #1;
        chk("AN", {3'b0, AN}, {3'b0, e_an});
        chk("seg", seg, e_seg);
        chk("DP", {6'b0, DP}, {6'b0, e_dp});
        chk("frame_sync", {6'b0, frame_sync}, {6'b0, e_fs});
        chk("pending", {6'b0, pending}, {6'b0, m_pend});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align(input int phase);
        while ((k % FRAME) != phase) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dpm,
                           input logic [3:0] blk, input logic lz);
        digits = d; digit_en = en; dp_mask = dpm; blink_mask = blk; lz_blank = lz;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0111111;
        for (int i = 11; i < 16; i++) seg_tab[i] = 7'b1111111;

        // Reset, then two dark frames with no load.
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(64);

        // Mid-frame load of 0123 with DP on digit 2, no blanking.
        align(10);
        do_load(16'h0123, 4'hF, 4'b0100, 4'b0000, 1'b0);
        run(70);

        // Leading-zero blanking on, then all-zero value.
        do_load(16'h0123, 4'hF, 4'b0100, 4'b0000, 1'b1);
        run(45);
        do_load(16'h0000, 4'hF, 4'b1111, 4'b0000, 1'b1);
        run(45);

        // Minus sign, blank code, partial digit enable.
        do_load(16'hA0C5, 4'hF, 4'b0000, 4'b0000, 1'b0);
        run(45);
        do_load(16'h4876, 4'b0101, 4'b1111, 4'b0000, 1'b0);
        run(45);

        // Blink digit 0 across several blink half-periods.
        do_load(16'h9999, 4'hF, 4'b0000, 4'b0001, 1'b0);
        run(160);

        // Two loads in one frame: last wins.
        align(5);
        do_load(16'h0111, 4'hF, 4'b0000, 4'b0000, 1'b0);
        run(6);
        do_load(16'h0222, 4'hF, 4'b0000, 4'b0000, 1'b0);
        run(40);

        // Load exactly on the boundary cycle.
        align(FRAME - 1);
        do_load(16'h5678, 4'hF, 4'b0011, 4'b0000, 1'b0);
        run(33);

        // Reset mid-frame discards shown and staged data.
        align(13);
        do_load(16'h3333, 4'hF, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(40);

        // Randomized loads at random times, including occasional boundary hits.
        do_load(16'h1234, 4'hF, 4'b0000, 4'b0000, 1'b0);
        for (int it = 0; it < 30; it++) begin
            run($urandom_range(0, 40));
            do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        run(70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
